piso_tx_arbiter: RTL and testbench
==================================

# piso_tx_arbiter

Controller that shares one parallel-in/serial-out shift datapath between two parallel-word requesters. It arbitrates round-robin, loads the winner's word, and sequences the LSB-first shift-out with a framing strobe. Each frame is followed by a programmable idle gap. It sits between word producers and a single serial output pin/lane.

## Interface

Parameters:
- WIDTH, 4, data word width in bits (≥2)
- GAP, 1, idle cycles inserted after each frame (≥0)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid
- req1_valid  input  1  requester 1 has a word
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle when high with req1_valid
- so  output  1  serial data out; 0 when so_valid low
- so_valid  output  1  high for every bit cycle of a frame
- frame_start  output  1  high on the first bit cycle of a frame only
- owner  output  1  requester index of the current frame; holds last value when idle
- busy  output  1  high in any state other than IDLE

## Operation

- States: IDLE, SHIFT, PARITY (only with PISO_TX_PARITY_EN), GAP.
- IDLE: the grant goes to the single valid requester. If both are valid, it goes to the one not served last. The rr pointer resets to "last = 1", so requester 0 wins the first tie.
- reqN_ready = (state == IDLE) && grantN. A ready is never asserted without its valid, and is always 0 outside IDLE.
- Accept edge (valid & ready):
  - shift reg <= data
  - bit counter <= 0
  - owner <= N
  - pointer <= N
  - state -> SHIFT
- SHIFT:
  - so = shift reg[0], so_valid = 1.
  - On each edge: shift reg >>= 1 (zero fill) and counter++.
  - On the edge where counter == WIDTH-1, go to PARITY if enabled. Otherwise go to GAP if GAP > 0, else IDLE.
- PARITY: one cycle, so = XOR of the accepted word, so_valid = 1. Then go to GAP, or to IDLE if GAP == 0.
- GAP: so_valid = 0 for exactly GAP cycles (gap counter), then IDLE.
- Data word is captured only at accept. Input changes mid-frame have no effect. The valid of the non-served requester is ignored until IDLE.
- Counters are sized $clog2(WIDTH) and $clog2(GAP+1) (minimum 1 bit). They never wrap within a frame.

## Timing

- Reset values: so=0, so_valid=0, frame_start=0, owner=0, busy=0, req*_ready=0 (ready stays 0 until a valid arrives), state=IDLE, pointer last=1.
- Reset asserted mid-frame: the frame is truncated immediately (asynchronous), no partial bits resume, and the pointer is restored.
- Latency: the first bit appears on so in the cycle right after the accept edge.
- Frame occupancy: WIDTH (+1 with parity) bit cycles, then GAP idle cycles, then one IDLE cycle minimum before the next accept.
- Accept period: WIDTH + GAP + 1 cycles (+1 with parity).
- so, so_valid and frame_start are registered (decoded from state/regs, no input-to-output comb path). Readies are combinational from state and valids.

## Configuration

- PISO_TX_PARITY_EN defined: the PARITY state exists and one even-parity bit is appended after the data bits. so_valid spans WIDTH+1 cycles.
- Not defined: there is no PARITY state and so_valid spans exactly WIDTH cycles. No parity logic is synthesized.

## Structure

- Package piso_tx_pkg holds:
  - state enum (IDLE, SHIFT, PARITY, GAP)
  - requester index type
  - localparam NUM_REQ = 2
- Sub-module piso_shift_core (WIDTH): load, shift_en, d, q0. It holds the shift register only. The arbiter and FSM stay in the top module.

## Test plan

- Only req0_valid with req0_data=4'b1011 after reset: req0_ready pulses 1 cycle. The next cycles give so = 1,1,0,1 with so_valid high for 4 cycles, frame_start on the first cycle, and owner=0. Then so_valid is low for 1 GAP cycle.
- Both valid continuously after reset with data0=4'b0001, data1=4'b1000: frames alternate owner 0,1,0,1. The accept period is 6 cycles (WIDTH=4, GAP=1, no parity).
- Only req1 valid back-to-back: req1 is served every frame, with no idle slots beyond GAP+1.
- Data changed and other valid asserted mid-SHIFT: the serial bits match the word captured at accept, and both readies stay 0 until IDLE.
- rst asserted at the third bit: so, so_valid and busy drop to 0 asynchronously. After release, a tie goes to req0.
- With PISO_TX_PARITY_EN and data=4'b0111: so = 1,1,1,0 then parity 1, with so_valid high for 5 cycles.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types for the two-requester PISO transmit arbiter.
// Optional parity bit is enabled with the PISO_TX_PARITY_EN macro.
package piso_tx_pkg;

  // Number of parallel-word requesters sharing the serial lane.
  localparam int NUM_REQ = 2;

  // Frame sequencer states; ST_PARITY is only reachable with PISO_TX_PARITY_EN.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Index of a requester (0 or 1).
  typedef logic req_idx_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Parallel-load, LSB-first shift register; zero-fills from the top on shift.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] sr_q;

  // Load has priority over shift so an accept always captures a fresh word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift_en) begin
      sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign q0 = sr_q[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter plus frame sequencer in front of one PISO shifter.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
//
// Handshake: a requester's word is taken on the rising edge where its valid
// and ready are both high; ready is only ever high in IDLE, for the granted
// requester, and never without that requester's valid.
module piso_tx_arbiter
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             owner,
  output logic             busy
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  req_idx_t         owner_q, owner_d;
  req_idx_t         last_q, last_d;

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] ready_vec;
  logic               accept;
  req_idx_t           win_idx;
  logic [WIDTH-1:0]   win_data;
  logic               load;
  logic               shift_en;
  logic               q0;

  // Grant: a lone valid wins; on a tie the requester not served last wins.
  always_comb begin
    valid_vec = {req1_valid, req0_valid};
    if (&valid_vec) begin
      grant_vec = (last_q == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      grant_vec = valid_vec;
    end
    ready_vec = (state_q == ST_IDLE) ? grant_vec : '0;
    accept    = |ready_vec;
    win_idx   = grant_vec[1];
    win_data  = win_idx ? req1_data : req0_data;
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // Next-state and datapath controls for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          owner_d = win_idx;
          last_d  = win_idx;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == BIT_LAST) begin
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          if (GAP > 0) begin
            gcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        if (GAP > 0) begin
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset truncates any frame and re-arms the tie to req0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  // Even parity of the accepted word, sent after the last data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^win_data;
    end
  end
`endif

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .d        (win_data),
    .q0       (q0)
  );

  // Serial outputs decoded purely from registers, so no input reaches them.
  always_comb begin
    so          = 1'b0;
    so_valid    = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        so          = q0;
        so_valid    = 1'b1;
        frame_start = (cnt_q == '0);
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        so       = par_q;
        so_valid = 1'b1;
      end
`endif
      default: begin
        so = 1'b0;
      end
    endcase
  end

  assign owner = owner_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Self-checking bench for piso_tx_arbiter (WIDTH=4, GAP=1).
// The reference model expands each accepted word into a queue of expected
// serial cycles (data bits, optional parity, gap) and arbitrates by rule.
module tb_piso_tx_arbiter;

  localparam int WIDTH = 4;
  localparam int GAP   = 1;
  localparam logic [3:0] T1_WORD = 4'b1011;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             so, so_valid, frame_start, owner, busy;

  piso_tx_arbiter #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .so          (so),
    .so_valid    (so_valid),
    .frame_start (frame_start),
    .owner       (owner),
    .busy        (busy)
  );

  // Scoreboard: each entry is {so, so_valid, frame_start} for one cycle.
  logic [2:0] exp_q[$];
  logic       m_last;
  logic       m_owner;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which requester the rules say should be granted given current valids.
  function automatic logic [1:0] model_grant();
    if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
    return {req1_valid, req0_valid};
  endfunction

  task automatic push_frame(input logic [WIDTH-1:0] word);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back({word[i], 1'b1, (i == 0)});
`ifdef PISO_TX_PARITY_EN
    exp_q.push_back({^word, 1'b1, 1'b0});
`endif
    for (int i = 0; i < GAP; i++) exp_q.push_back(3'b000);
  endtask

  task automatic compare_outputs();
    logic [1:0] g;
    logic [2:0] e;
    g = (exp_q.size() == 0) ? model_grant() : 2'b00;
    e = (exp_q.size() != 0) ? exp_q[0] : 3'b000;
    check_eq("so", so, e[2]);
    check_eq("so_valid", so_valid, e[1]);
    check_eq("frame_start", frame_start, e[0]);
    check_eq("busy", busy, exp_q.size() != 0);
    check_eq("owner", owner, m_owner);
    check_eq("req0_ready", req0_ready, g[0]);
    check_eq("req1_ready", req1_ready, g[1]);
  endtask

  // Driver: inputs are set at the falling edge; check, then advance one clock.
  task automatic step();
    logic [1:0] g;
    logic       idx;
    #1 compare_outputs();
    @(posedge clk);
    if (exp_q.size() == 0) begin
      g = model_grant();
      if (g != 2'b00) begin
        idx     = g[1];
        m_owner = idx;
        m_last  = idx;
        push_frame(idx ? req1_data : req0_data);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last  = 1'b1;
    m_owner = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Single requester 0 with a known word; check bits against constants too.
    req0_valid = 1'b1;
    req0_data  = T1_WORD;
    step();
    req0_valid = 1'b0;
    req0_data  = 4'b0100;
    for (int i = 0; i < WIDTH; i++) begin
      #1 check_eq("t1_bit", so, T1_WORD[i]);
      step();
    end
    repeat (4) step();

    // Both requesters contending: frames alternate.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 4'b0001;
    req1_data  = 4'b1000;
    repeat (24) step();

    // Requester 1 alone, back to back.
    req0_valid = 1'b0;
    req1_data  = 4'b0110;
    repeat (18) step();

    // Random valids and data every cycle, including changes mid-frame.
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_data  = WIDTH'($urandom);
      req1_data  = WIDTH'($urandom);
      step();
    end

    // Reset during the third bit of a frame.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (WIDTH + GAP + 3) step();
    req0_valid = 1'b1;
    req0_data  = WIDTH'($urandom);
    step();
    req0_valid = 1'b0;
    step();
    step();
    #1 compare_outputs();
    rst = 1'b1;
    #1;
    check_eq("rst_so", so, 1'b0);
    check_eq("rst_so_valid", so_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst        = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 4'b1100;
    req1_data  = 4'b0011;
    step();
    #1 check_eq("tie_after_rst_owner", owner, 1'b0);
    repeat (14) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
